// File: rtl/multiply_core_evo_pkg.sv
// Shared elaboration-time helpers for the evo dot-product engine: tree depth,
// padded lane count, tree output width and the legal-radix test.
package multiply_core_evo_pkg;

  function automatic int int_pow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Smallest n with radix**n >= len; a single lane needs no tree at all.
  function automatic int tree_levels(input int len, input int radix);
    int n;
    int p;
    n = 0;
    p = 1;
    while (p < len) begin
      p = p * radix;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic int tree_width(input int dw, input int len, input int radix);
    return 2 * dw + tree_levels(len, radix) * $clog2(radix);
  endfunction

  function automatic bit radix_legal(input int radix);
    return (radix == 2) || (radix == 3);
  endfunction

endpackage

// File: rtl/multiply_core_evo_radix_tree.sv
// Registered radix-2/3 adder tree; one register per level, full-precision
// output, lanes beyond LANES padded with zero.
module multiply_core_evo_radix_tree
  import multiply_core_evo_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int LANES  = 4,
  parameter  int RADIX  = 2,
  parameter  int SIGNED = 0,
  localparam int LEVELS = tree_levels(LANES, RADIX),
  localparam int OUT_W  = WIDTH + LEVELS * $clog2(RADIX)
) (
  input  logic                   clk,
  input  logic [LANES*WIDTH-1:0] lanes_in,
  output logic [OUT_W-1:0]       sum_out
);

  localparam int PAD = int_pow(RADIX, LEVELS);

  logic [OUT_W-1:0] lane_ext [PAD];

  for (genvar e = 0; e < PAD; e++) begin : g_lane
    if (e >= LANES) begin : g_zero
      assign lane_ext[e] = '0;
    end else if (SIGNED != 0) begin : g_sext
      assign lane_ext[e] = OUT_W'($signed(lanes_in[e*WIDTH +: WIDTH]));
    end else begin : g_zext
      assign lane_ext[e] = OUT_W'(lanes_in[e*WIDTH +: WIDTH]);
    end
  end

  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    localparam int N = PAD / int_pow(RADIX, lv);
    logic [OUT_W-1:0] prev  [N*RADIX];
    logic [OUT_W-1:0] sum_d [N];
    logic [OUT_W-1:0] sum_q [N];

    if (lv == 1) begin : g_src_in
      assign prev = lane_ext;
    end else begin : g_src_lvl
      assign prev = g_lvl[lv-1].sum_q;
    end

    always_comb begin
      for (int n = 0; n < N; n++) begin
        sum_d[n] = '0;
        for (int c = 0; c < RADIX; c++) sum_d[n] = sum_d[n] + prev[n*RADIX + c];
      end
    end

    always_ff @(posedge clk) sum_q <= sum_d;
  end

  if (LEVELS == 0) begin : g_flat
    assign sum_out = lane_ext[0];
  end else begin : g_root
    assign sum_out = g_lvl[LEVELS].sum_q[0];
  end

endmodule

// File: rtl/vc_cycle_buffer.sv
// Fixed-depth data delay line; carries sideband payload alongside the pipeline.
module vc_cycle_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: payload stages carry no reset; only the valid chain beside them needs one.
  always_ff @(posedge clk) begin
    stage_q[0] <= d_in;
    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/multiply_core_evo_acc.sv
// Pipelined dot-product engine: input reg, product reg, registered adder tree,
// then a group accumulator that emits sum, overflow and addresses on last.
module multiply_core_evo_acc
  import multiply_core_evo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_LENGTH     = 64,
  parameter int RADIX           = 2,
  parameter int SIGNED          = 0,
  parameter int ACC_WIDTH       = 32,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] row,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] col,
  input  logic                              val_in,
  input  logic                              last_in,
  input  logic [ADDRESS_WIDTH_I-1:0]        addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]        addr_k_in,
  output logic [ACC_WIDTH-1:0]              sum_out,
  output logic                              val_out,
  output logic                              ovf_out,
  output logic [ADDRESS_WIDTH_I-1:0]        addr_i_out,
  output logic [ADDRESS_WIDTH_K-1:0]        addr_k_out
);

  localparam int L  = tree_levels(DATA_LENGTH, RADIX);
  localparam int TW = tree_width(DATA_WIDTH, DATA_LENGTH, RADIX);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SB = L + 2;
  localparam int AW = ADDRESS_WIDTH_I + ADDRESS_WIDTH_K;

  if (!radix_legal(RADIX)) begin : g_bad_radix
    $error("multiply_core_evo_acc: RADIX must be 2 or 3");
  end
  if (DATA_LENGTH < 1) begin : g_bad_len
    $error("multiply_core_evo_acc: DATA_LENGTH must be >= 1");
  end
  if (ACC_WIDTH < TW) begin : g_bad_acc
    $error("multiply_core_evo_acc: ACC_WIDTH must be >= tree width");
  end

  logic [DATA_WIDTH*DATA_LENGTH-1:0] row_q, col_q;
  logic [PW*DATA_LENGTH-1:0]         prod_d, prod_q;
  logic [TW-1:0]                     tree_out;

  always_ff @(posedge clk) begin
    row_q  <= row;
    col_q  <= col;
    prod_q <= prod_d;
  end

  // Operands are widened to 2*DATA_WIDTH first so the low half of the product
  // is exact for both unsigned and two's-complement inputs.
  always_comb begin
    logic [PW-1:0] a_ext, b_ext;
    prod_d = '0;
    for (int e = 0; e < DATA_LENGTH; e++) begin
      a_ext = {{DATA_WIDTH{(SIGNED != 0) && row_q[(e+1)*DATA_WIDTH-1]}}, row_q[e*DATA_WIDTH +: DATA_WIDTH]};
      b_ext = {{DATA_WIDTH{(SIGNED != 0) && col_q[(e+1)*DATA_WIDTH-1]}}, col_q[e*DATA_WIDTH +: DATA_WIDTH]};
      prod_d[e*PW +: PW] = a_ext * b_ext;
    end
  end

  multiply_core_evo_radix_tree #(
    .WIDTH (PW),
    .LANES (DATA_LENGTH),
    .RADIX (RADIX),
    .SIGNED(SIGNED)
  ) u_tree (
    .clk     (clk),
    .lanes_in(prod_q),
    .sum_out (tree_out)
  );

  logic [SB-1:0] val_sb_q, last_sb_q;
  logic [AW-1:0] addr_sb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_sb_q  <= '0;
      last_sb_q <= '0;
    end else begin
      val_sb_q  <= {val_sb_q[SB-2:0], val_in};
      last_sb_q <= {last_sb_q[SB-2:0], val_in & last_in};
    end
  end

  vc_cycle_buffer #(.WIDTH(AW), .DEPTH(SB)) u_addr_dly (
    .clk  (clk),
    .d_in ({addr_i_in, addr_k_in}),
    .d_out(addr_sb)
  );

  logic [ACC_WIDTH-1:0]       acc_q, acc_d, sum_out_q, sum_out_d;
  logic                       ovf_q, ovf_d, open_q, open_d;
  logic                       ovf_out_q, ovf_out_d, val_out_q, val_out_d;
  logic [ADDRESS_WIDTH_I-1:0] ai_q, ai_d;
  logic [ADDRESS_WIDTH_K-1:0] ak_q, ak_d;
  logic [ACC_WIDTH-1:0]       tree_ext, acc_base;
  logic [ACC_WIDTH:0]         add_full;
  logic                       add_ovf, ovf_next;

  assign tree_ext = (SIGNED != 0) ? ACC_WIDTH'($signed(tree_out)) : ACC_WIDTH'(tree_out);
  assign acc_base = open_q ? acc_q : '0;
  assign add_full = {1'b0, acc_base} + {1'b0, tree_ext};
  assign add_ovf  = (SIGNED != 0)
                  ? ((acc_base[ACC_WIDTH-1] == tree_ext[ACC_WIDTH-1]) &&
                     (add_full[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]))
                  : add_full[ACC_WIDTH];
  assign ovf_next = (open_q & ovf_q) | add_ovf;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    open_d    = open_q;
    sum_out_d = sum_out_q;
    ovf_out_d = ovf_out_q;
    ai_d      = ai_q;
    ak_d      = ak_q;
    val_out_d = 1'b0;
    if (val_sb_q[SB-1]) begin
      acc_d  = add_full[ACC_WIDTH-1:0];
      ovf_d  = ovf_next;
      open_d = !last_sb_q[SB-1];
      if (last_sb_q[SB-1]) begin
        sum_out_d    = add_full[ACC_WIDTH-1:0];
        ovf_out_d    = ovf_next;
        {ai_d, ak_d} = addr_sb;
        val_out_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      open_q    <= 1'b0;
      sum_out_q <= '0;
      ovf_out_q <= 1'b0;
      ai_q      <= '0;
      ak_q      <= '0;
      val_out_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      open_q    <= open_d;
      sum_out_q <= sum_out_d;
      ovf_out_q <= ovf_out_d;
      ai_q      <= ai_d;
      ak_q      <= ak_d;
      val_out_q <= val_out_d;
    end
  end

  assign sum_out    = sum_out_q;
  assign ovf_out    = ovf_out_q;
  assign val_out    = val_out_q;
  assign addr_i_out = ai_q;
  assign addr_k_out = ak_q;

endmodule

// File: tb/tb_multiply_core_evo_acc.sv
// Directed bench: four engine configurations sharing one stimulus stream,
// table of single-beat groups plus hand-written multi-cycle sequences.
module tb_multiply_core_evo_acc;

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic [7:0]  ai;
    logic [7:0]  ak;
    logic [31:0] exp_base;
    logic [31:0] exp_sgn;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] sum;
    logic        ovf;
    logic [7:0]  ai;
    logic [7:0]  ak;
  } em_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] row4, col4;
  logic [39:0] row5, col5;
  logic        val_in, last_in;
  logic [7:0]  ai_in, ak_in;

  logic [31:0] b_sum, s_sum, r_sum;
  logic [17:0] a_sum;
  logic        b_val, s_val, a_val, r_val;
  logic        b_ovf, s_ovf, a_ovf, r_ovf;
  logic [7:0]  b_ai, b_ak, s_ai, s_ak, a_ai, a_ak, r_ai, r_ak;

  int cyc_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  em_t q_base[$], q_sgn[$], q_a18[$], q_r3[$];
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  multiply_core_evo_acc #(.DATA_WIDTH(8), .DATA_LENGTH(4), .RADIX(2), .SIGNED(0), .ACC_WIDTH(32)) u_base (
    .clk(clk), .reset(rst), .row(row4), .col(col4), .val_in(val_in), .last_in(last_in),
    .addr_i_in(ai_in), .addr_k_in(ak_in), .sum_out(b_sum), .val_out(b_val), .ovf_out(b_ovf),
    .addr_i_out(b_ai), .addr_k_out(b_ak));

  multiply_core_evo_acc #(.DATA_WIDTH(8), .DATA_LENGTH(4), .RADIX(2), .SIGNED(1), .ACC_WIDTH(32)) u_sgn (
    .clk(clk), .reset(rst), .row(row4), .col(col4), .val_in(val_in), .last_in(last_in),
    .addr_i_in(ai_in), .addr_k_in(ak_in), .sum_out(s_sum), .val_out(s_val), .ovf_out(s_ovf),
    .addr_i_out(s_ai), .addr_k_out(s_ak));

  multiply_core_evo_acc #(.DATA_WIDTH(8), .DATA_LENGTH(4), .RADIX(2), .SIGNED(0), .ACC_WIDTH(18)) u_a18 (
    .clk(clk), .reset(rst), .row(row4), .col(col4), .val_in(val_in), .last_in(last_in),
    .addr_i_in(ai_in), .addr_k_in(ak_in), .sum_out(a_sum), .val_out(a_val), .ovf_out(a_ovf),
    .addr_i_out(a_ai), .addr_k_out(a_ak));

  multiply_core_evo_acc #(.DATA_WIDTH(8), .DATA_LENGTH(5), .RADIX(3), .SIGNED(0), .ACC_WIDTH(32)) u_r3 (
    .clk(clk), .reset(rst), .row(row5), .col(col5), .val_in(val_in), .last_in(last_in),
    .addr_i_in(ai_in), .addr_k_in(ak_in), .sum_out(r_sum), .val_out(r_val), .ovf_out(r_ovf),
    .addr_i_out(r_ai), .addr_k_out(r_ak));

  // Emission log, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (b_val) q_base.push_back('{cyc_cnt, b_sum, b_ovf, b_ai, b_ak});
    if (s_val) q_sgn.push_back('{cyc_cnt, s_sum, s_ovf, s_ai, s_ak});
    if (a_val) q_a18.push_back('{cyc_cnt, {14'b0, a_sum}, a_ovf, a_ai, a_ak});
    if (r_val) q_r3.push_back('{cyc_cnt, r_sum, r_ovf, r_ai, r_ak});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] r, input logic [31:0] c,
                       input logic [39:0] r5, input logic [39:0] c5,
                       input logic [7:0] ai, input logic [7:0] ak, output int cyc_at);
    @(negedge clk);
    val_in  = v;
    last_in = l;
    row4    = r;
    col4    = c;
    row5    = r5;
    col5    = c5;
    ai_in   = ai;
    ak_in   = ak;
    cyc_at  = cyc_cnt;
  endtask

  task automatic idle(input int n);
    int unused_c;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, unused_c);
  endtask

  task automatic clear_logs();
    q_base.delete();
    q_sgn.delete();
    q_a18.delete();
    q_r3.delete();
  endtask

  initial begin
    int c, c1, c2, c3;

    tbl[0] = '{32'h04030201, 32'h08070605, 8'd3,   8'd9,   32'd70,     32'd70};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hAA,  8'h55,  32'd260100, 32'd4};
    tbl[2] = '{32'hFFFFFFFF, 32'h02020202, 8'd1,   8'd2,   32'd2040,   32'hFFFF_FFF8};
    tbl[3] = '{32'h00000000, 32'h00000000, 8'hFF,  8'h00,  32'd0,      32'd0};
    tbl[4] = '{32'h80808080, 32'h7F7F7F7F, 8'd17,  8'd34,  32'd65024,  32'hFFFF_0200};
    tbl[5] = '{32'h00000080, 32'h00000080, 8'd200, 8'd100, 32'd16384,  32'd16384};

    rst = 1'b1;
    val_in = 1'b0; last_in = 1'b0;
    row4 = '0; col4 = '0; row5 = '0; col5 = '0; ai_in = '0; ak_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sum", b_sum, 32'd0);
    check("rst_val", 32'(b_val), 32'd0);
    check("rst_ovf", 32'(b_ovf), 32'd0);
    check("rst_ai", 32'(b_ai), 32'd0);
    check("rst_ak", 32'(b_ak), 32'd0);
    idle(2);

    // Single-beat groups: latency, value, addresses, one-cycle pulse, hold.
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      drive(1'b1, 1'b1, tbl[i].row, tbl[i].col, '0, '0, tbl[i].ai, tbl[i].ak, c);
      idle(8);
      check($sformatf("v%0d_count", i), 32'(q_base.size()), 32'd1);
      if (q_base.size() > 0) begin
        check($sformatf("v%0d_latency", i), 32'(q_base[0].cyc), 32'(c + 5));
        check($sformatf("v%0d_sum", i), q_base[0].sum, tbl[i].exp_base);
        check($sformatf("v%0d_ovf", i), 32'(q_base[0].ovf), 32'd0);
        check($sformatf("v%0d_ai", i), 32'(q_base[0].ai), 32'(tbl[i].ai));
        check($sformatf("v%0d_ak", i), 32'(q_base[0].ak), 32'(tbl[i].ak));
      end
      check($sformatf("v%0d_hold", i), b_sum, tbl[i].exp_base);
      check($sformatf("v%0d_sgn_count", i), 32'(q_sgn.size()), 32'd1);
      if (q_sgn.size() > 0) check($sformatf("v%0d_sgn_sum", i), q_sgn[0].sum, tbl[i].exp_sgn);
    end

    // Three-beat group with garbage bubbles, then a back-to-back single beat.
    clear_logs();
    drive(1'b1, 1'b0, 32'h04030201, 32'h08070605, '0, '0, 8'd1, 8'd1, c);
    drive(1'b0, 1'b1, $urandom, $urandom, '0, '0, 8'hEE, 8'hEE, c);
    drive(1'b1, 1'b0, 32'h02020202, 32'h0A0A0A0A, '0, '0, 8'd2, 8'd2, c);
    drive(1'b0, 1'b1, $urandom, $urandom, '0, '0, 8'hDD, 8'hDD, c);
    drive(1'b1, 1'b1, 32'h03030303, 32'h05050505, '0, '0, 8'd5, 8'd6, c1);
    drive(1'b1, 1'b1, 32'h04030201, 32'h08070605, '0, '0, 8'd3, 8'd9, c2);
    idle(8);
    check("grp_count", 32'(q_base.size()), 32'd2);
    if (q_base.size() > 1) begin
      check("grp_latency", 32'(q_base[0].cyc), 32'(c1 + 5));
      check("grp_sum", q_base[0].sum, 32'd210);
      check("grp_ai", 32'(q_base[0].ai), 32'd5);
      check("grp_ak", 32'(q_base[0].ak), 32'd6);
      check("b2b_latency", 32'(q_base[1].cyc), 32'(c2 + 5));
      check("b2b_sum", q_base[1].sum, 32'd70);
    end

    // Radix-3 tree with five lanes padded to nine.
    clear_logs();
    drive(1'b1, 1'b1, '0, '0, {40{1'b1}}, {40{1'b1}}, 8'd7, 8'd8, c);
    idle(8);
    check("r3_count", 32'(q_r3.size()), 32'd1);
    if (q_r3.size() > 0) begin
      check("r3_latency", 32'(q_r3[0].cyc), 32'(c + 5));
      check("r3_sum", q_r3[0].sum, 32'd325125);
    end

    // Narrow accumulator: wrap with sticky overflow, cleared by the next group.
    clear_logs();
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 8'h11, 8'h22, c1);
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 8'h11, 8'h22, c2);
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 8'h33, 8'h44, c3);
    idle(8);
    check("a18_count", 32'(q_a18.size()), 32'd2);
    if (q_a18.size() > 1) begin
      check("a18_wrap_sum", q_a18[0].sum, 32'd258056);
      check("a18_wrap_ovf", 32'(q_a18[0].ovf), 32'd1);
      check("a18_next_sum", q_a18[1].sum, 32'd260100);
      check("a18_next_ovf", 32'(q_a18[1].ovf), 32'd0);
      check("a18_next_latency", 32'(q_a18[1].cyc), 32'(c3 + 5));
    end
    if (q_base.size() > 0) check("wide_no_wrap_sum", q_base[0].sum, 32'd520200);

    // Asynchronous reset in the middle of an open group.
    clear_logs();
    drive(1'b1, 1'b0, 32'h04030201, 32'h08070605, '0, '0, 8'd9, 8'd9, c);
    drive(1'b1, 1'b0, 32'h04030201, 32'h08070605, '0, '0, 8'd9, 8'd9, c);
    @(posedge clk);
    #2;
    rst = 1'b1;
    val_in = 1'b0;
    last_in = 1'b0;
    #1;
    check("arst_sum", b_sum, 32'd0);
    check("arst_ai", 32'(b_ai), 32'd0);
    check("arst_ak", 32'(b_ak), 32'd0);
    check("arst_ovf", 32'(b_ovf), 32'd0);
    check("arst_val", 32'(b_val), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(10);
    check("arst_no_emit", 32'(q_base.size()), 32'd0);
    drive(1'b1, 1'b1, 32'h04030201, 32'h08070605, '0, '0, 8'd3, 8'd9, c);
    idle(8);
    check("post_rst_count", 32'(q_base.size()), 32'd1);
    if (q_base.size() > 0) begin
      check("post_rst_sum", q_base[0].sum, 32'd70);
      check("post_rst_ai", 32'(q_base[0].ai), 32'd3);
      check("post_rst_ak", 32'(q_base[0].ak), 32'd9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiply_core_evo_acc.md
Name: multiply_core_evo_acc

Overview:
- Next-generation pipelined dot-product engine with accumulation.
- Each valid beat multiplies DATA_LENGTH element pairs. A registered adder tree of selectable radix (2 or 3) reduces the products at full precision.
- The tree results of consecutive beats are accumulated into an ACC_WIDTH sum until a beat tagged last_in. The total is then emitted with its addresses and an overflow flag.
- Sits between the operand buffers and the output writeback of the tree-MAC array.

Parameters:
- DATA_WIDTH, 8: element width of row/col operands.
- DATA_LENGTH, 64: elements per beat; must be ≥1.
- RADIX, 2: adder-tree fan-in; only 2 or 3 are legal, any other value is an elaboration error.
- SIGNED, 0: 1 = operands and products are two's complement; 0 = unsigned.
- ACC_WIDTH, 32: accumulator and sum_out width; must be ≥ TREE_WIDTH, otherwise elaboration error.
- ADDRESS_WIDTH_I, 8: width of addr_i sideband.
- ADDRESS_WIDTH_K, 8: width of addr_k sideband.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- row  in  DATA_WIDTH*DATA_LENGTH  packed operands; element e is at bits [(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH]
- col  in  DATA_WIDTH*DATA_LENGTH  packed operands, same packing as row
- val_in  in  1  beat valid
- last_in  in  1  final beat of an accumulation group; qualified by val_in
- addr_i_in  in  ADDRESS_WIDTH_I  beat address i
- addr_k_in  in  ADDRESS_WIDTH_K  beat address k
- sum_out  out  ACC_WIDTH  accumulated group result
- val_out  out  1  one-cycle pulse; sum_out is valid
- ovf_out  out  1  group overflowed ACC_WIDTH; valid with val_out
- addr_i_out  out  ADDRESS_WIDTH_I  addr_i of the group's last beat
- addr_k_out  out  ADDRESS_WIDTH_K  addr_k of the group's last beat

Behaviour:
- Derived constants, computed with integer arithmetic only:
  - L = smallest n with RADIX^n ≥ DATA_LENGTH (L = 0 when DATA_LENGTH = 1).
  - PAD = RADIX^L.
  - TREE_WIDTH = 2*DATA_WIDTH + L*clog2(RADIX).
- Pipeline stages:
  - S0: input register.
  - S1: product register, full 2*DATA_WIDTH bits, signed or unsigned per SIGNED.
  - S2..S(L+1): one register per tree level. Each node sums RADIX children with width extension; lanes DATA_LENGTH..PAD-1 are constant 0.
  - Final stage: accumulator register.
- Latency: val_out is asserted L+3 cycles after the val_in/last_in beat that closes the group.
- Throughput: one beat per cycle. There is no backpressure and no stall; the datapath is free-running.
- Datapath S0–tree registers have no reset.
- val, last, addr_i and addr_k travel in a sideband chain of depth L+2 aligned with the tree output. This chain resets to 0.
- Accumulation is applied only when the aligned valid is 1; invalid beats leave acc, ovf and the outputs untouched.
- Accumulator update:
  - The tree result is sign- or zero-extended to ACC_WIDTH.
  - If a group is open: acc_next = acc + ext.
  - If no group is open (after reset or after a last beat): acc_next = ext. Back-to-back groups therefore need no idle cycle.
- Overflow:
  - Overflow is detected on each addition (unsigned carry-out, or signed sign overflow).
  - ovf is sticky within a group and clears when a new group starts.
  - The sum wraps modulo 2^ACC_WIDTH; there is no saturation.
- Emission on an aligned valid beat with last = 1, in the same cycle edge:
  - sum_out ← acc_next and ovf_out ← ovf_next.
  - addr_i_out and addr_k_out ← that beat's addresses.
  - val_out = 1 for exactly one cycle.
  - sum_out, ovf_out and the addr outputs hold their values until the next emission.
- A single-beat group (last_in on its first beat) emits that beat's dot product.
- Reset:
  - Asynchronous; clears sum_out, ovf_out, addr_i_out, addr_k_out, val_out, the accumulator, the group-open flag and the sideband chain.
  - Beats in flight are discarded, so a group interrupted by reset never emits.
  - The first valid beat after reset starts a new group.
- last_in with val_in = 0 is ignored.

Decomposition:
- Package multiply_core_evo_pkg holds:
  - Integer functions tree_levels(len, radix), int_pow(b, e) and tree_width(dw, len, radix).
  - The legal-radix check.
- Sub-module multiply_core_evo_radix_tree: parametrised registered tree taking (width, lanes, radix, signed). It is reusable by future MAC variants.
- The sideband delay uses vc_cycle_buffer for data; the valid/last chain uses resettable registers.

Test Plan:
Unless stated, DATA_WIDTH=8, DATA_LENGTH=4, RADIX=2, ACC_WIDTH=32, unsigned; latency is L+3 = 5.
1. One beat, row=[1,2,3,4], col=[5,6,7,8], last=1, addr_i=3, addr_k=9 at cycle t → at t+5: val_out=1 for one cycle, sum_out=70, ovf_out=0, addr_i_out=3, addr_k_out=9.
2. Group of three beats, with val_in=0 garbage bubbles between them and last on the third → exactly one val_out, 5 cycles after the third beat, sum_out=210. Then a back-to-back single-beat group on the next cycle → 70 one cycle later.
3. SIGNED=1, row all 8'hFF, col all 8'h02, last=1 → sum_out=32'hFFFF_FFF8 (−8).
4. RADIX=3, DATA_LENGTH=5 (PAD=9, L=2), all operands 255, last=1 → sum_out=325125 at t+5.
5. ACC_WIDTH=18, all operands 255, two-beat group → sum_out=258056 with ovf_out=1. A following single-beat group → sum_out=260100 with ovf_out=0.
6. Two beats of a group, then reset asserted asynchronously mid-cycle for one cycle → all outputs are 0 immediately and no emission occurs. A later single beat of test 1 → sum_out=70.
